vga_timing_multi: RTL
=====================

VGA_TIMING_MULTI -- requirements
Module: vga_timing_multi

Interface
REQ-001 Parameter CNT_W, default 11: width of hcount/vcount.
REQ-002 Parameter DEFAULT_MODE, default 2: mode index loaded at reset.
REQ-003 pclk  in  1  pixel clock; the single clock, all logic on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 mode_sel  in  2  requested mode: 0=640x480, 1=800x600, 2=1024x768, 3=reserved.
REQ-006 mode_req  in  1  one-cycle strobe; samples mode_sel.
REQ-007 hcount, vcount  out  CNT_W each  current pixel/line position.
REQ-008 hsync, vsync  out  1 each  sync pulses at the active mode's polarity.
REQ-009 hblnk, vblnk  out  1 each  high outside the visible area.
REQ-010 frame_start  out  1  one-cycle pulse when hcount=0 and vcount=0.
REQ-011 mode_active  out  2  mode currently being generated.
REQ-012 mode_ack  out  1  one-cycle pulse on the first pixel of a newly applied mode.
REQ-013 mode_err  out  1  one-cycle pulse, the cycle after a mode_req with mode_sel=3.

Function
REQ-014 Mode table (Htot/Hvis/HSs/HSe, Vtot/Vvis/VSs/VSe, pol): m0 800/640/656/752, 525/480/490/492, negative; m1 1056/800/840/968, 628/600/601/605, positive; m2 1344/1024/1048/1184, 806/768/771/777, negative.
REQ-015 hcount increments every cycle and wraps Htot-1 -> 0; vcount increments on each hcount wrap and wraps Vtot-1 -> 0.
REQ-016 hblnk = (hcount >= Hvis) and vblnk = (vcount >= Vvis).
REQ-017 hsync is active for HSs <= hcount < HSe, vsync for VSs <= vcount < VSe; "active" means high for positive polarity and low for negative.
REQ-018 All outputs are registered and consistent with the hcount/vcount values presented in the same cycle; no combinational path from any input to any output.
REQ-019 A valid mode_req (mode_sel 0..2) loads a pending register; a later request before it is applied overwrites it (last wins).
REQ-020 A pending mode is applied at the frame boundary: in the cycle following hcount=Htot-1, vcount=Vtot-1 of the old mode, outputs show 0,0 with the new mode's table, mode_active updated, and mode_ack=1.
REQ-021 A request equal to the current mode is still acknowledged at the next boundary; the timing is unchanged.
REQ-022 mode_req with mode_sel=3 is dropped: the pending register is unchanged and mode_err pulses.
REQ-023 A mode_req arriving in the boundary cycle itself is applied at the following frame boundary, not the current one.
REQ-024 The timing sequence never shows a partial line or frame: a mode change occurs only at the boundary.
REQ-025 Counter arithmetic is unsigned CNT_W-bit; CNT_W < 11 is an elaboration error.

Reset
REQ-026 While rst_n=0: hcount=vcount=0, mode_active=DEFAULT_MODE, pending cleared, hblnk=vblnk=0, frame_start=mode_ack=mode_err=0, hsync/vsync at the inactive level of DEFAULT_MODE.
REQ-027 Assertion of reset mid-frame aborts the frame immediately and discards any pending request.
REQ-028 On the first edge after deassertion: counters advance from 0,0 and frame_start=1 while at 0,0.

Structure
REQ-029 Package vga_modes_pkg holds the per-mode timing constants, the mode index encoding and the polarity flags.
REQ-030 Sub-module vga_mode_table (combinational: mode index -> timing fields) is instantiated once, addressed by mode_active.
REQ-031 The block drop-in replaces vga_timing in the top level; the existing consumers of hcount/vcount/hsync/vsync/hblnk/vblnk are unchanged.

Verification
REQ-032 Reset release in mode 2 -> line period 1344 cycles, frame period 1344*806 cycles, hsync low for hcount 1048..1183, hblnk high from hcount 1024.
REQ-033 mode_req with mode_sel=0 mid-frame -> current frame completes; next cycle hcount=0, vcount=0, mode_active=0, mode_ack=1; next line period is 800 cycles.
REQ-034 Requests 1 then 0 within one frame -> only mode 0 applied, single mode_ack.
REQ-035 mode_sel=1 -> hsync high only for hcount 840..967, vsync high only for vcount 601..604.
REQ-036 mode_req with mode_sel=3 -> mode_err pulse, no mode_ack, timing unchanged; mode_req at the boundary cycle -> applied one frame later.
REQ-037 rst_n low at hcount=500, vcount=300 with a request pending -> outputs at reset values; after release, DEFAULT_MODE timing and no mode_ack.

Source files
------------

// File: rtl/vga_modes_pkg.sv
// Per-mode VGA timing constants, mode index encoding and sync polarity flags.
package vga_modes_pkg;

  typedef enum logic [1:0] {
    MODE_640X480  = 2'd0,
    MODE_800X600  = 2'd1,
    MODE_1024X768 = 2'd2,
    MODE_RSVD     = 2'd3
  } mode_e;

  // Native width of the table constants; counters may be wider.
  localparam int unsigned TIM_W = 11;

  typedef struct packed {
    logic [TIM_W-1:0] htot;
    logic [TIM_W-1:0] hvis;
    logic [TIM_W-1:0] hss;
    logic [TIM_W-1:0] hse;
    logic [TIM_W-1:0] vtot;
    logic [TIM_W-1:0] vvis;
    logic [TIM_W-1:0] vss;
    logic [TIM_W-1:0] vse;
    logic             pos_pol;
  } timing_t;

  localparam timing_t TIM_640 = '{htot: 11'd800, hvis: 11'd640, hss: 11'd656, hse: 11'd752,
                                  vtot: 11'd525, vvis: 11'd480, vss: 11'd490, vse: 11'd492,
                                  pos_pol: 1'b0};
  localparam timing_t TIM_800 = '{htot: 11'd1056, hvis: 11'd800, hss: 11'd840, hse: 11'd968,
                                  vtot: 11'd628, vvis: 11'd600, vss: 11'd601, vse: 11'd605,
                                  pos_pol: 1'b1};
  localparam timing_t TIM_1024 = '{htot: 11'd1344, hvis: 11'd1024, hss: 11'd1048, hse: 11'd1184,
                                   vtot: 11'd806, vvis: 11'd768, vss: 11'd771, vse: 11'd777,
                                   pos_pol: 1'b0};

  // The reserved index never reaches the timing path; it maps to 1024x768.
  function automatic timing_t mode_timing(input mode_e m);
    timing_t t;
    case (m)
      MODE_640X480: t = TIM_640;
      MODE_800X600: t = TIM_800;
      default:      t = TIM_1024;
    endcase
    return t;
  endfunction

  function automatic logic mode_pos_pol(input mode_e m);
    timing_t t;
    t = mode_timing(m);
    return t.pos_pol;
  endfunction

endpackage

// File: rtl/vga_mode_table.sv
// Combinational lookup: mode index -> timing fields widened to the counter width.
module vga_mode_table
  import vga_modes_pkg::*;
#(
  parameter int unsigned CNT_W = 11
) (
  input  mode_e            mode,
  output logic [CNT_W-1:0] htot,
  output logic [CNT_W-1:0] hvis,
  output logic [CNT_W-1:0] hss,
  output logic [CNT_W-1:0] hse,
  output logic [CNT_W-1:0] vtot,
  output logic [CNT_W-1:0] vvis,
  output logic [CNT_W-1:0] vss,
  output logic [CNT_W-1:0] vse,
  output logic             pos_pol
);

  timing_t t;

  // Fetch the mode entry and zero-extend each field.
  always_comb begin
    t       = mode_timing(mode);
    htot    = CNT_W'(t.htot);
    hvis    = CNT_W'(t.hvis);
    hss     = CNT_W'(t.hss);
    hse     = CNT_W'(t.hse);
    vtot    = CNT_W'(t.vtot);
    vvis    = CNT_W'(t.vvis);
    vss     = CNT_W'(t.vss);
    vse     = CNT_W'(t.vse);
    pos_pol = t.pos_pol;
  end

endmodule

// File: rtl/vga_timing_multi.sv
// Multi-mode VGA timing generator; mode changes take effect only at frame boundaries.
module vga_timing_multi
  import vga_modes_pkg::*;
#(
  parameter int unsigned CNT_W        = 11,
  parameter int unsigned DEFAULT_MODE = 2
) (
  input  logic             pclk,
  input  logic             rst_n,
  input  logic [1:0]       mode_sel,
  input  logic             mode_req,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             hblnk,
  output logic             vblnk,
  output logic             frame_start,
  output logic [1:0]       mode_active,
  output logic             mode_ack,
  output logic             mode_err
);

  if (CNT_W < 11) begin : g_cnt_w_check
    $error("vga_timing_multi: CNT_W must be at least 11");
  end
  if (DEFAULT_MODE > 2) begin : g_def_mode_check
    $error("vga_timing_multi: DEFAULT_MODE must be 0..2");
  end

  localparam mode_e DEF_MODE = mode_e'(DEFAULT_MODE[1:0]);
  localparam logic  DEF_POS  = mode_pos_pol(DEF_MODE);

  mode_e            mode_q, pend_mode, mode_nxt;
  logic             pend_valid, run;
  logic [CNT_W-1:0] htot, hvis, hss, hse, vtot, vvis, vss, vse;
  logic             pos_pol;
  logic [CNT_W-1:0] h_nxt, v_nxt;
  logic             at_hend, at_vend, apply, req_ok;
  logic             hs_on, vs_on, pol_nxt;

  assign mode_active = mode_q;

  vga_mode_table #(.CNT_W(CNT_W)) u_table (
    .mode    (mode_q),
    .htot    (htot),
    .hvis    (hvis),
    .hss     (hss),
    .hse     (hse),
    .vtot    (vtot),
    .vvis    (vvis),
    .vss     (vss),
    .vse     (vse),
    .pos_pol (pos_pol)
  );

  // Next position, boundary detection and next-cycle sync levels.
  always_comb begin
    at_hend  = (hcount == htot - CNT_W'(1));
    at_vend  = (vcount == vtot - CNT_W'(1));
    apply    = run && at_hend && at_vend && pend_valid;
    req_ok   = mode_req && (mode_sel != 2'd3);
    mode_nxt = apply ? pend_mode : mode_q;
    h_nxt    = hcount + CNT_W'(1);
    v_nxt    = vcount;
    if (!run) begin
      // First edge after reset presents 0,0 so frame_start marks it.
      h_nxt = '0;
      v_nxt = '0;
    end else if (at_hend) begin
      h_nxt = '0;
      v_nxt = at_vend ? '0 : vcount + CNT_W'(1);
    end
    // Windows come from the current table; on a mode switch the next position
    // is 0,0 which precedes every sync window, so only the polarity must follow
    // the incoming mode.
    hs_on   = (h_nxt >= hss) && (h_nxt < hse);
    vs_on   = (v_nxt >= vss) && (v_nxt < vse);
    pol_nxt = apply ? mode_pos_pol(pend_mode) : pos_pol;
  end

  // Registered counters, outputs and pending-mode bookkeeping.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      run         <= 1'b0;
      hcount      <= '0;
      vcount      <= '0;
      hblnk       <= 1'b0;
      vblnk       <= 1'b0;
      hsync       <= ~DEF_POS;
      vsync       <= ~DEF_POS;
      frame_start <= 1'b0;
      mode_ack    <= 1'b0;
      mode_err    <= 1'b0;
      mode_q      <= DEF_MODE;
      pend_mode   <= DEF_MODE;
      pend_valid  <= 1'b0;
    end else begin
      run         <= 1'b1;
      hcount      <= h_nxt;
      vcount      <= v_nxt;
      hblnk       <= (h_nxt >= hvis);
      vblnk       <= (v_nxt >= vvis);
      hsync       <= pol_nxt ? hs_on : ~hs_on;
      vsync       <= pol_nxt ? vs_on : ~vs_on;
      frame_start <= (h_nxt == '0) && (v_nxt == '0);
      mode_ack    <= apply;
      mode_err    <= mode_req && (mode_sel == 2'd3);
      mode_q      <= mode_nxt;
      if (apply) begin
        pend_valid <= 1'b0;
      end
      // A request sampled on the boundary edge itself waits for the next frame.
      if (req_ok) begin
        pend_valid <= 1'b1;
        pend_mode  <= mode_e'(mode_sel);
      end
    end
  end

endmodule
